// File: rtl/display_mode_scheduler_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : display_pkg
//  Description : Shared types, segment constants and BCD decoder for the
//                display mode scheduler.
//  Revision    : 1.0 - initial release
// ============================================================================
package display_pkg;

    // Top-level scheduler state
    typedef enum logic [0:0] {
        ST_NORMAL = 1'b0,
        ST_ALARM  = 1'b1
    } state_e;

    // Segment encoding: bit0 = a .. bit6 = g, active high
    localparam logic [6:0] SEG_DASH  = 7'b1000000;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    // Digit patterns, entry i holds the pattern for decimal digit i
    localparam logic [9:0][6:0] SEG_DIGITS = {
        7'b1101111,   // 9
        7'b1111111,   // 8
        7'b0000111,   // 7
        7'b1111101,   // 6
        7'b1101101,   // 5
        7'b1100110,   // 4
        7'b1001111,   // 3
        7'b1011011,   // 2
        7'b0000110,   // 1
        7'b0111111    // 0
    };

    // Non-decimal codes show a dash so corrupted data is visible on the board
    function automatic logic [6:0] bcd_to_seg7(input logic [3:0] bcd);
        logic [6:0] seg;
        if (bcd <= 4'd9) begin
            seg = SEG_DIGITS[bcd];
        end else begin
            seg = SEG_DASH;
        end
        return seg;
    endfunction

endpackage
`default_nettype wire

// File: rtl/display_mode_scheduler_if.sv
`default_nettype none
// ============================================================================
//  Module      : display_mode_scheduler_if
//  Description : Button, source-data and board-pin bundle of the display
//                mode scheduler.
//  Revision    : 1.0 - initial release
// ============================================================================
interface display_mode_scheduler_if;

    logic        mode_btn;
    logic        any_btn;
    logic [23:0] src0_bcd;
    logic [23:0] src1_bcd;
    logic [23:0] src2_bcd;
    logic [23:0] src3_bcd;
    logic        edit_en;
    logic [2:0]  edit_digit;
    logic        alarm_req;

    logic [6:0]  seg1;
    logic [6:0]  seg2;
    logic [6:0]  seg3;
    logic [6:0]  seg4;
    logic [6:0]  seg5;
    logic [6:0]  seg6;
    logic        led1;
    logic        led2;
    logic        led3;
    logic        led4;
    logic        led5;
    logic        led6;
    logic [1:0]  cur_mode;
    logic        alarm_active;

    // Side that owns the buttons and time-keeping sources
    modport master (
        output mode_btn, any_btn, src0_bcd, src1_bcd, src2_bcd, src3_bcd,
               edit_en, edit_digit, alarm_req,
        input  seg1, seg2, seg3, seg4, seg5, seg6,
               led1, led2, led3, led4, led5, led6,
               cur_mode, alarm_active
    );

    // Scheduler side
    modport slave (
        input  mode_btn, any_btn, src0_bcd, src1_bcd, src2_bcd, src3_bcd,
               edit_en, edit_digit, alarm_req,
        output seg1, seg2, seg3, seg4, seg5, seg6,
               led1, led2, led3, led4, led5, led6,
               cur_mode, alarm_active
    );

endinterface
`default_nettype wire

// File: rtl/display_mode_scheduler_btn_debounce.sv
`default_nettype none
// ============================================================================
//  Module      : btn_debounce
//  Description : Counter-based push-button debouncer with rising-edge pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module btn_debounce #(
    parameter int DEBOUNCE_CYC = 20
) (
    input  wire logic clk,
    input  wire logic reset,
    input  wire logic raw,
    output logic      level,
    output logic      pulse
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             pulse_q, pulse_d;

    // Count consecutive cycles that disagree with the accepted level
    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        pulse_d = 1'b0;
        if (raw != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = raw;
                pulse_d = raw;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Debounce state register
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q   <= '0;
            level_q <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            level_q <= level_d;
            pulse_q <= pulse_d;
        end
    end

    assign level = level_q;
    assign pulse = pulse_q;

endmodule
`default_nettype wire

// File: rtl/display_mode_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : display_mode_scheduler
//  Description : Multiplexes up to four time-keeping sources onto six
//                7-segment digits and six LEDs, with alarm preemption and
//                edit-digit blinking. All pin outputs are registered.
//  Revision    : 1.0 - initial release
// ============================================================================
module display_mode_scheduler
    import display_pkg::*;
#(
    parameter int N_MODES        = 4,
    parameter int DEBOUNCE_CYC   = 20,
    parameter int BLINK_HALF_CYC = 500,
    parameter int ALARM_HOLD_CYC = 30000,
    parameter int ALARM_SRC      = 1
) (
    input wire logic                clk,
    input wire logic                reset,
    display_mode_scheduler_if.slave bus
);

    localparam int BLINK_W = $clog2(BLINK_HALF_CYC + 1);
    localparam int HOLD_W  = $clog2(ALARM_HOLD_CYC + 1);

    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_HALF_CYC - 1);
    localparam logic [HOLD_W-1:0]  HOLD_LOAD  = HOLD_W'(ALARM_HOLD_CYC - 1);
    localparam logic [1:0]         LAST_MODE  = 2'(N_MODES - 1);
    localparam logic [1:0]         ALARM_IDX  = 2'(ALARM_SRC);

    // ------------------------------------------------------------------
    // Button conditioning
    // ------------------------------------------------------------------
    logic w_mode_level_unused;
    logic w_any_level_unused;
    logic w_mode_p;
    logic w_any_p;

    btn_debounce #(
        .DEBOUNCE_CYC (DEBOUNCE_CYC)
    ) u_mode_db (
        .clk   (clk),
        .reset (reset),
        .raw   (bus.mode_btn),
        .level (w_mode_level_unused),
        .pulse (w_mode_p)
    );

    btn_debounce #(
        .DEBOUNCE_CYC (DEBOUNCE_CYC)
    ) u_any_db (
        .clk   (clk),
        .reset (reset),
        .raw   (bus.any_btn),
        .level (w_any_level_unused),
        .pulse (w_any_p)
    );

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_e              state_q, state_d;
    logic [1:0]          mode_q, mode_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic                alarm_req_q;
    logic [BLINK_W-1:0]  blink_q;
    logic                phase_q;
    logic [6:0]          seg_q [6];
    logic [6:0]          seg_d [6];
    logic [5:0]          led_q, led_d;

    logic                w_alarm_edge;
    logic [23:0]         w_src [4];
    logic [23:0]         w_disp_src;
    logic                w_in_alarm;

    assign w_alarm_edge = bus.alarm_req & ~alarm_req_q;
    assign w_in_alarm   = (state_q == ST_ALARM);

    assign w_src[0] = bus.src0_bcd;
    assign w_src[1] = bus.src1_bcd;
    assign w_src[2] = bus.src2_bcd;
    assign w_src[3] = bus.src3_bcd;

    // Mode/alarm sequencing; an alarm edge wins over a same-cycle mode press
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        hold_d  = hold_q;
        case (state_q)
            ST_NORMAL: begin
                if (w_alarm_edge) begin
                    state_d = ST_ALARM;
                    hold_d  = HOLD_LOAD;
                end else if (w_mode_p && !bus.edit_en) begin
                    mode_d = (mode_q == LAST_MODE) ? 2'd0 : mode_q + 2'd1;
                end
            end
            ST_ALARM: begin
                // Any dismissal press only leaves the alarm; it never advances the mode
                if (w_mode_p || w_any_p || (hold_q == '0)) begin
                    state_d = ST_NORMAL;
                    hold_d  = '0;
                end else begin
                    hold_d = hold_q - 1'b1;
                end
            end
            default: begin
                state_d = ST_NORMAL;
            end
        endcase
    end

    // State, mode, hold counter and alarm edge-detect registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= ST_NORMAL;
            mode_q      <= '0;
            hold_q      <= '0;
            alarm_req_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            hold_q      <= hold_d;
            alarm_req_q <= bus.alarm_req;
        end
    end

    // Free-running blink timebase; phase 1 is the blank half
    always_ff @(posedge clk) begin
        if (!reset) begin
            blink_q <= '0;
            phase_q <= 1'b0;
        end else if (blink_q == BLINK_LAST) begin
            blink_q <= '0;
            phase_q <= ~phase_q;
        end else begin
            blink_q <= blink_q + 1'b1;
        end
    end

    // Select the visible source, decode digits and apply blanking
    always_comb begin
        w_disp_src = w_in_alarm ? w_src[ALARM_IDX] : w_src[mode_q];
        for (int k = 0; k < 6; k++) begin
            seg_d[k] = bcd_to_seg7(w_disp_src[4*(5-k) +: 4]);
            if (w_in_alarm && phase_q) begin
                seg_d[k] = SEG_BLANK;
            end
            if (!w_in_alarm && bus.edit_en && phase_q &&
                (bus.edit_digit == 3'(k))) begin
                seg_d[k] = SEG_BLANK;
            end
        end
        led_d = '0;
        for (int k = 0; k < 4; k++) begin
            led_d[k] = !w_in_alarm && (mode_q == 2'(k));
        end
        led_d[4] = bus.edit_en & ~w_in_alarm;
        led_d[5] = w_in_alarm & ~phase_q;
    end

    // Pin registers for segments and LEDs
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int k = 0; k < 6; k++) begin
                seg_q[k] <= SEG_BLANK;
            end
            led_q <= '0;
        end else begin
            for (int k = 0; k < 6; k++) begin
                seg_q[k] <= seg_d[k];
            end
            led_q <= led_d;
        end
    end

    assign bus.seg1 = seg_q[0];
    assign bus.seg2 = seg_q[1];
    assign bus.seg3 = seg_q[2];
    assign bus.seg4 = seg_q[3];
    assign bus.seg5 = seg_q[4];
    assign bus.seg6 = seg_q[5];

    assign bus.led1 = led_q[0];
    assign bus.led2 = led_q[1];
    assign bus.led3 = led_q[2];
    assign bus.led4 = led_q[3];
    assign bus.led5 = led_q[4];
    assign bus.led6 = led_q[5];

    assign bus.cur_mode     = mode_q;
    assign bus.alarm_active = w_in_alarm;

endmodule
`default_nettype wire

// File: tb/tb_display_mode_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_display_mode_scheduler
//  Description : Directed self-checking bench for display_mode_scheduler.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_display_mode_scheduler;

    localparam int N_MODES        = 3;
    localparam int DEBOUNCE_CYC   = 20;
    localparam int BLINK_HALF_CYC = 500;
    localparam int ALARM_HOLD_CYC = 1000;
    localparam int ALARM_SRC      = 1;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    display_mode_scheduler_if tif ();

    display_mode_scheduler #(
        .N_MODES        (N_MODES),
        .DEBOUNCE_CYC   (DEBOUNCE_CYC),
        .BLINK_HALF_CYC (BLINK_HALF_CYC),
        .ALARM_HOLD_CYC (ALARM_HOLD_CYC),
        .ALARM_SRC      (ALARM_SRC)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (tif)
    );

    always #5 clk = ~clk;

    // Non-reset edges since the last reset; drives the blink-phase model
    int n_cyc = 0;
    always @(posedge clk) begin
        if (!reset) n_cyc <= 0;
        else        n_cyc <= n_cyc + 1;
    end

    int n_assert = 0;
    int n_fail   = 0;

    typedef struct {
        string      tag;
        logic [1:0] mode;
        logic       alarm;
    } exp_t;

    exp_t sb[$];

    function automatic logic [6:0] ref_seg(input logic [3:0] v);
        case (v)
            4'd0:    return 7'b0111111;
            4'd1:    return 7'b0000110;
            4'd2:    return 7'b1011011;
            4'd3:    return 7'b1001111;
            4'd4:    return 7'b1100110;
            4'd5:    return 7'b1101101;
            4'd6:    return 7'b1111101;
            4'd7:    return 7'b0000111;
            4'd8:    return 7'b1111111;
            4'd9:    return 7'b1101111;
            default: return 7'b1000000;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int k);
        repeat (k) @(negedge clk);
    endtask

    task automatic expect_state(input string tag, input logic [1:0] m, input logic a);
        exp_t e;
        e.tag   = tag;
        e.mode  = m;
        e.alarm = a;
        sb.push_back(e);
    endtask

    function automatic logic [41:0] obs_segs();
        return {tif.seg1, tif.seg2, tif.seg3, tif.seg4, tif.seg5, tif.seg6};
    endfunction

    function automatic logic [5:0] obs_leds();
        return {tif.led6, tif.led5, tif.led4, tif.led3, tif.led2, tif.led1};
    endfunction

    // Pop the oldest expectation and compare it with the pins now
    task automatic check_sb();
        exp_t        e;
        logic [23:0] s;
        logic        ph;
        logic [41:0] es;
        logic [5:0]  el;
        logic [6:0]  d;
        if (sb.size() == 0) begin
            chk("scoreboard.nonempty", 64'd0, 64'd1);
            return;
        end
        e  = sb.pop_front();
        ph = (n_cyc > 0) && ((((n_cyc - 1) / BLINK_HALF_CYC) % 2) == 1);
        if (e.alarm)          s = tif.src1_bcd;
        else if (e.mode == 0) s = tif.src0_bcd;
        else if (e.mode == 1) s = tif.src1_bcd;
        else if (e.mode == 2) s = tif.src2_bcd;
        else                  s = tif.src3_bcd;
        for (int k = 0; k < 6; k++) begin
            d = ref_seg(s[4*(5-k) +: 4]);
            if (e.alarm && ph) d = 7'b0;
            if (!e.alarm && tif.edit_en && ph && (int'(tif.edit_digit) == k)) d = 7'b0;
            es[7*(5-k) +: 7] = d;
        end
        el = '0;
        for (int k = 0; k < 4; k++) el[k] = !e.alarm && (int'(e.mode) == k);
        el[4] = tif.edit_en && !e.alarm;
        el[5] = e.alarm && !ph;
        chk({e.tag, ".mode"},  64'(tif.cur_mode),     64'(e.mode));
        chk({e.tag, ".alarm"}, 64'(tif.alarm_active), 64'(e.alarm));
        chk({e.tag, ".segs"},  64'(obs_segs()),       64'(es));
        chk({e.tag, ".leds"},  64'(obs_leds()),       64'(el));
    endtask

    task automatic press_mode(input string tag, input logic [1:0] m, input logic a);
        expect_state(tag, m, a);
        tif.mode_btn = 1'b1;
        tick(25);
        tif.mode_btn = 1'b0;
        tick(25);
        check_sb();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".mode"},  64'(tif.cur_mode),     64'd0);
        chk({tag, ".alarm"}, 64'(tif.alarm_active), 64'd0);
        chk({tag, ".segs"},  64'(obs_segs()),       64'd0);
        chk({tag, ".leds"},  64'(obs_leds()),       64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout expected end of stimulus");
        $fatal(1, "watchdog expired");
    end

    initial begin
        tif.mode_btn   = 1'b0;
        tif.any_btn    = 1'b0;
        tif.edit_en    = 1'b0;
        tif.edit_digit = 3'd0;
        tif.alarm_req  = 1'b0;
        tif.src0_bcd   = 24'h123456;
        tif.src1_bcd   = 24'h654321;
        tif.src2_bcd   = 24'h987012;
        tif.src3_bcd   = 24'hABCDEF;
        reset = 1'b0;
        tick(3);
        chk_all_zero("reset");

        reset = 1'b1;
        tick(5);
        expect_state("idle", 2'd0, 1'b0);
        check_sb();

        // Held press: mode advances one edge after the debounced pulse
        tif.mode_btn = 1'b1;
        tick(20);
        chk("t1.before", 64'(tif.cur_mode), 64'd0);
        tick(1);
        chk("t1.mode",     64'(tif.cur_mode), 64'd1);
        chk("t1.seg_lag",  64'(tif.seg1),     64'(ref_seg(4'h1)));
        chk("t1.led_lag",  64'(obs_leds()),   64'b000001);
        expect_state("t1.next", 2'd1, 1'b0);
        tick(1);
        check_sb();
        tick(3);
        tif.mode_btn = 1'b0;
        expect_state("t1.release", 2'd1, 1'b0);
        tick(25);
        check_sb();

        // Short glitch is rejected
        tif.mode_btn = 1'b1;
        tick(10);
        tif.mode_btn = 1'b0;
        expect_state("glitch", 2'd1, 1'b0);
        tick(30);
        check_sb();

        // Wrap at N_MODES-1
        press_mode("press.2", 2'd2, 1'b0);
        press_mode("press.0", 2'd0, 1'b0);

        // Edit blink on digit 3, dash on the non-BCD digit
        tif.src0_bcd   = 24'h12345A;
        tif.edit_en    = 1'b1;
        tif.edit_digit = 3'd2;
        tick(2);
        chk("edit.dash", 64'(tif.seg6), 64'b1000000);
        for (int i = 0; i < 4; i++) begin
            expect_state("edit.blink", 2'd0, 1'b0);
            check_sb();
            tick(250);
        end
        press_mode("edit.ignore", 2'd0, 1'b0);
        tif.edit_en = 1'b0;
        tick(2);

        // Alarm edge coincides with the mode pulse
        tif.mode_btn = 1'b1;
        tick(20);
        tif.alarm_req = 1'b1;
        tick(1);
        chk("al.entry.alarm", 64'(tif.alarm_active), 64'd1);
        chk("al.entry.mode",  64'(tif.cur_mode),     64'd0);
        tick(4);
        tif.mode_btn = 1'b0;
        for (int i = 0; i < 3; i++) begin
            expect_state("alarm.show", 2'd0, 1'b1);
            tick(30);
            check_sb();
        end
        tif.any_btn = 1'b1;
        tick(20);
        chk("al.dismiss.before", 64'(tif.alarm_active), 64'd1);
        tick(1);
        chk("al.dismiss.alarm", 64'(tif.alarm_active), 64'd0);
        chk("al.dismiss.mode",  64'(tif.cur_mode),     64'd0);
        tick(4);
        tif.any_btn = 1'b0;
        expect_state("al.held_no_retrigger", 2'd0, 1'b0);
        tick(30);
        check_sb();

        // Timeout after exactly ALARM_HOLD_CYC cycles
        tif.alarm_req = 1'b0;
        tick(2);
        tif.alarm_req = 1'b1;
        tick(1);
        chk("to.entry", 64'(tif.alarm_active), 64'd1);
        tick(ALARM_HOLD_CYC - 1);
        chk("to.last_cycle", 64'(tif.alarm_active), 64'd1);
        tick(1);
        chk("to.expired", 64'(tif.alarm_active), 64'd0);
        tick(50);
        chk("to.no_retrigger", 64'(tif.alarm_active), 64'd0);
        tif.alarm_req = 1'b0;
        tick(2);

        // Reset during an alarm with mode 2
        press_mode("rst.m1", 2'd1, 1'b0);
        press_mode("rst.m2", 2'd2, 1'b0);
        tif.alarm_req = 1'b1;
        tick(2);
        chk("rst.pre.alarm", 64'(tif.alarm_active), 64'd1);
        chk("rst.pre.mode",  64'(tif.cur_mode),     64'd2);
        reset = 1'b0;
        tick(1);
        chk_all_zero("rst.mid_alarm");
        reset = 1'b1;
        tif.alarm_req = 1'b0;
        tick(2);

        chk("scoreboard.drained", 64'(sb.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
